// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by hazard_ctrl and hazard_fwd_sel.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EM = 2'b01;
  localparam logic [1:0] FWD_MW = 2'b10;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       raw;
    logic       load_use;
    logic [1:0] fwd;
  } src_hit_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand source match against EX/MEM/WB writers.
// Reports RAW and load-use hits plus the bypass select.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_used,
  input  logic [4:0] rd_e,
  input  logic       we_e,
  input  logic       load_e,
  input  logic [4:0] rd_m,
  input  logic       we_m,
  input  logic [4:0] rd_w,
  input  logic       we_w,
  output src_hit_t   hit
);

  logic rs_nz;
  logic hit_e;
  logic hit_m;
  logic hit_w;

  assign rs_nz = (rs != 5'd0);
  assign hit_e = rs_nz & we_e & (rd_e == rs);
  assign hit_m = rs_nz & we_m & (rd_m == rs);
  assign hit_w = rs_nz & we_w & (rd_w == rs);

  // MEM result is younger than WB, so it wins the bypass.
  always_comb begin
    hit.raw      = rs_used & (hit_e | hit_m);
    hit.load_use = rs_used & load_e & hit_e;
    if (hit_m)
      hit.fwd = FWD_EM;
    else if (hit_w)
      hit.fwd = FWD_MW;
    else
      hit.fwd = FWD_RF;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory wait, redirect, load-use, RAW.
// Define HAZARD_FWD_EN to enable operand bypassing instead of RAW stalls.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic        USE_RS1_D,
  input  logic        USE_RS2_D,
  input  logic [4:0]  RD_E,
  input  logic        WE_E,
  input  logic        LOAD_E,
  input  logic        BR_TAKEN_E,
  input  logic [4:0]  RD_M,
  input  logic        WE_M,
  input  logic [4:0]  RD_W,
  input  logic        WE_W,
  input  logic        DMEM_REQ_M,
  input  logic        DMEM_ACK_M,
  output logic        STALL_F,
  output logic        STALL_FD,
  output logic        STALL_DE,
  output logic        STALL_EM,
  output logic        FLUSH_FD,
  output logic        FLUSH_DE,
  output logic        BUBBLE_MW,
  output logic [1:0]  FWD_A,
  output logic [1:0]  FWD_B,
  output logic [15:0] STALL_CNT,
  output logic        MEM_TIMEOUT
);

  state_t     state;
  logic [7:0] wcnt;
  src_hit_t   hit_a;
  src_hit_t   hit_b;
  logic       mem_wait;
  logic       ld_use;
  logic       raw_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  hazard_fwd_sel u_sel_a (
    .rs      (RS1_D),
    .rs_used (USE_RS1_D),
    .rd_e    (RD_E),
    .we_e    (WE_E),
    .load_e  (LOAD_E),
    .rd_m    (RD_M),
    .we_m    (WE_M),
    .rd_w    (RD_W),
    .we_w    (WE_W),
    .hit     (hit_a)
  );

  hazard_fwd_sel u_sel_b (
    .rs      (RS2_D),
    .rs_used (USE_RS2_D),
    .rd_e    (RD_E),
    .we_e    (WE_E),
    .load_e  (LOAD_E),
    .rd_m    (RD_M),
    .we_m    (WE_M),
    .rd_w    (RD_W),
    .we_w    (WE_W),
    .hit     (hit_b)
  );

  assign ld_use = hit_a.load_use | hit_b.load_use;

`ifdef HAZARD_FWD_EN
  logic unused_raw;
  assign fwd_a      = hit_a.fwd;
  assign fwd_b      = hit_b.fwd;
  assign raw_stall  = 1'b0;
  assign unused_raw = hit_a.raw ^ hit_b.raw;
`else
  logic unused_fwd;
  assign fwd_a      = FWD_RF;
  assign fwd_b      = FWD_RF;
  assign raw_stall  = hit_a.raw | hit_b.raw;
  assign unused_fwd = ^{hit_a.fwd, hit_b.fwd};
`endif

  // The first unacked request cycle already stalls, before MWAIT is entered.
  assign mem_wait = ~DMEM_ACK_M & ((state == MWAIT) | DMEM_REQ_M);

  // Priority: memory wait, then redirect, then load-use / RAW.
  always_comb begin
    STALL_F   = 1'b0;
    STALL_FD  = 1'b0;
    STALL_DE  = 1'b0;
    STALL_EM  = 1'b0;
    FLUSH_FD  = 1'b0;
    FLUSH_DE  = 1'b0;
    BUBBLE_MW = 1'b0;
    FWD_A     = FWD_RF;
    FWD_B     = FWD_RF;
    if (RST) begin
      FLUSH_FD = 1'b1;
      FLUSH_DE = 1'b1;
    end else begin
      if (mem_wait) begin
        STALL_F   = 1'b1;
        STALL_FD  = 1'b1;
        STALL_DE  = 1'b1;
        STALL_EM  = 1'b1;
        BUBBLE_MW = 1'b1;
      end else if (BR_TAKEN_E) begin
        FLUSH_FD = 1'b1;
        FLUSH_DE = 1'b1;
      end else if (ld_use | raw_stall) begin
        STALL_F  = 1'b1;
        STALL_FD = 1'b1;
        FLUSH_DE = 1'b1;
      end
      FWD_A = fwd_a;
      FWD_B = fwd_b;
    end
  end

  // Memory-wait FSM with wait-length counter and sticky timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      wcnt        <= 8'd0;
      MEM_TIMEOUT <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (DMEM_REQ_M & ~DMEM_ACK_M) begin
            state <= MWAIT;
            wcnt  <= 8'd0;
          end
        end
        MWAIT: begin
          if (DMEM_ACK_M) begin
            state <= RUN;
          end else begin
            if (wcnt != 8'hFF)
              wcnt <= wcnt + 8'd1;
            if (wcnt == TIMEOUT_LIMIT - 8'd1)
              MEM_TIMEOUT <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge CLK) begin
    if (RST)
      STALL_CNT <= 16'd0;
    else if (STALL_F && (STALL_CNT != 16'hFFFF))
      STALL_CNT <= STALL_CNT + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// Reference model is rule-based; directed literals pin the key cases.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RS1_D, RS2_D;
  logic        USE_RS1_D, USE_RS2_D;
  logic [4:0]  RD_E;
  logic        WE_E, LOAD_E, BR_TAKEN_E;
  logic [4:0]  RD_M;
  logic        WE_M;
  logic [4:0]  RD_W;
  logic        WE_W;
  logic        DMEM_REQ_M, DMEM_ACK_M;
  logic        STALL_F, STALL_FD, STALL_DE, STALL_EM;
  logic        FLUSH_FD, FLUSH_DE, BUBBLE_MW;
  logic [1:0]  FWD_A, FWD_B;
  logic [15:0] STALL_CNT;
  logic        MEM_TIMEOUT;

  hazard_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RS1_D(RS1_D), .RS2_D(RS2_D),
    .USE_RS1_D(USE_RS1_D), .USE_RS2_D(USE_RS2_D),
    .RD_E(RD_E), .WE_E(WE_E), .LOAD_E(LOAD_E),
    .BR_TAKEN_E(BR_TAKEN_E),
    .RD_M(RD_M), .WE_M(WE_M),
    .RD_W(RD_W), .WE_W(WE_W),
    .DMEM_REQ_M(DMEM_REQ_M), .DMEM_ACK_M(DMEM_ACK_M),
    .STALL_F(STALL_F), .STALL_FD(STALL_FD),
    .STALL_DE(STALL_DE), .STALL_EM(STALL_EM),
    .FLUSH_FD(FLUSH_FD), .FLUSH_DE(FLUSH_DE),
    .BUBBLE_MW(BUBBLE_MW),
    .FWD_A(FWD_A), .FWD_B(FWD_B),
    .STALL_CNT(STALL_CNT), .MEM_TIMEOUT(MEM_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  bit m_known = 0;
  bit m_wait  = 0;
  int m_wcnt  = 0;
  bit m_tmo   = 0;
  int m_scnt  = 0;

  // model expected combinational outputs
  bit e_sf, e_sfd, e_sde, e_sem, e_ffd, e_fde, e_bub;
  int e_fa, e_fb;

  function automatic bit hit(logic [4:0] rs, logic [4:0] rd, logic we);
    return we && (rs != 0) && (rd == rs);
  endfunction

  function automatic int fsel(logic [4:0] rs);
    if (hit(rs, RD_M, WE_M)) return 1;
    if (hit(rs, RD_W, WE_W)) return 2;
    return 0;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_eval();
    bit memw, lu, raw;
    e_sf = 0; e_sfd = 0; e_sde = 0; e_sem = 0;
    e_ffd = 0; e_fde = 0; e_bub = 0; e_fa = 0; e_fb = 0;
    if (RST) begin
      e_ffd = 1; e_fde = 1;
    end else begin
      memw = !DMEM_ACK_M && (m_wait || DMEM_REQ_M);
      lu = LOAD_E && ((USE_RS1_D && hit(RS1_D, RD_E, WE_E)) ||
                      (USE_RS2_D && hit(RS2_D, RD_E, WE_E)));
      raw = !FWD_ON &&
            ((USE_RS1_D && (hit(RS1_D, RD_E, WE_E) || hit(RS1_D, RD_M, WE_M))) ||
             (USE_RS2_D && (hit(RS2_D, RD_E, WE_E) || hit(RS2_D, RD_M, WE_M))));
      if (memw) begin
        e_sf = 1; e_sfd = 1; e_sde = 1; e_sem = 1; e_bub = 1;
      end else if (BR_TAKEN_E) begin
        e_ffd = 1; e_fde = 1;
      end else if (lu || raw) begin
        e_sf = 1; e_sfd = 1; e_fde = 1;
      end
      if (FWD_ON) begin
        e_fa = fsel(RS1_D);
        e_fb = fsel(RS2_D);
      end
    end
  endtask

  task automatic settle();
    @(negedge CLK);
    model_eval();
    chk("STALL_F", int'(STALL_F), int'(e_sf));
    chk("STALL_FD", int'(STALL_FD), int'(e_sfd));
    chk("STALL_DE", int'(STALL_DE), int'(e_sde));
    chk("STALL_EM", int'(STALL_EM), int'(e_sem));
    chk("FLUSH_FD", int'(FLUSH_FD), int'(e_ffd));
    chk("FLUSH_DE", int'(FLUSH_DE), int'(e_fde));
    chk("BUBBLE_MW", int'(BUBBLE_MW), int'(e_bub));
    chk("FWD_A", int'(FWD_A), e_fa);
    chk("FWD_B", int'(FWD_B), e_fb);
    if (m_known) begin
      chk("STALL_CNT", int'(STALL_CNT), m_scnt);
      chk("MEM_TIMEOUT", int'(MEM_TIMEOUT), int'(m_tmo));
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    if (RST) begin
      m_known = 1; m_wait = 0; m_wcnt = 0; m_tmo = 0; m_scnt = 0;
    end else begin
      if (e_sf && m_scnt < 65535) m_scnt++;
      if (!m_wait) begin
        if (DMEM_REQ_M && !DMEM_ACK_M) begin
          m_wait = 1; m_wcnt = 0;
        end
      end else if (DMEM_ACK_M) begin
        m_wait = 0;
      end else begin
        m_wcnt++;
        if (m_wcnt == 255) m_tmo = 1;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic idle();
    RST = 0;
    RS1_D = 0; RS2_D = 0; USE_RS1_D = 0; USE_RS2_D = 0;
    RD_E = 0; WE_E = 0; LOAD_E = 0; BR_TAKEN_E = 0;
    RD_M = 0; WE_M = 0; RD_W = 0; WE_W = 0;
    DMEM_REQ_M = 0; DMEM_ACK_M = 0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    cyc();
    RST = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    #1;
    // reset state
    settle();
    chk("rst_flush_fd", int'(FLUSH_FD), 1);
    chk("rst_stall_f", int'(STALL_F), 0);
    adv();
    settle();
    chk("rst_stall_cnt", int'(STALL_CNT), 0);
    chk("rst_timeout", int'(MEM_TIMEOUT), 0);
    adv();

    // load-use: lw x5 in EX, consumer reads x5
    idle();
    LOAD_E = 1; WE_E = 1; RD_E = 5; RS1_D = 5; USE_RS1_D = 1;
    settle();
    chk("lu_stall_f", int'(STALL_F), 1);
    chk("lu_flush_de", int'(FLUSH_DE), 1);
    adv();
    LOAD_E = 0; WE_E = 0; RD_E = 0; RD_W = 5; WE_W = 1;
    settle();
    chk("lu_after_stall", int'(STALL_F), 0);
    chk("lu_after_fwd_a", int'(FWD_A), FWD_ON ? 2 : 0);
    adv();

    // memory wait: ack low for 3 cycles
    do_reset();
    DMEM_REQ_M = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw_stall_f", int'(STALL_F), 1);
      chk("mw_bubble", int'(BUBBLE_MW), 1);
      adv();
    end
    DMEM_ACK_M = 1;
    settle();
    chk("mw_ack_stall_em", int'(STALL_EM), 0);
    chk("mw_stall_cnt", int'(STALL_CNT), 3);
    adv();
    idle();
    cyc();

    // branch frozen by memory wait
    BR_TAKEN_E = 1; DMEM_REQ_M = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("brw_flush_fd", int'(FLUSH_FD), 0);
      chk("brw_flush_de", int'(FLUSH_DE), 0);
      adv();
    end
    DMEM_ACK_M = 1;
    settle();
    chk("brx_flush_fd", int'(FLUSH_FD), 1);
    chk("brx_flush_de", int'(FLUSH_DE), 1);
    adv();
    idle();
    cyc();

    // x0 never hazards
    LOAD_E = 1; WE_E = 1; RD_E = 0; RS1_D = 0; USE_RS1_D = 1;
    settle();
    chk("x0_no_stall", int'(STALL_F), 0);
    adv();
    // EM beats WB
    idle();
    RS1_D = 7; USE_RS1_D = 1; RD_M = 7; WE_M = 1; RD_W = 7; WE_W = 1;
    settle();
    chk("em_prio_fwd_a", int'(FWD_A), FWD_ON ? 1 : 0);
    adv();

    // reset in mid-wait returns to RUN regardless of ack
    idle();
    DMEM_REQ_M = 1;
    cyc(); cyc();
    RST = 1;
    cyc();
    idle();
    settle();
    chk("rst_mwait_run", int'(STALL_F), 0);
    adv();

    // timeout: ack held low for 300 cycles
    do_reset();
    DMEM_REQ_M = 1;
    for (int i = 0; i < 300; i++) begin
      settle();
      if (i == 255) chk("tmo_before", int'(MEM_TIMEOUT), 0);
      if (i == 256) chk("tmo_set", int'(MEM_TIMEOUT), 1);
      adv();
    end
    DMEM_ACK_M = 1;
    cyc();
    idle();
    cyc(); cyc();
    settle();
    chk("tmo_sticky", int'(MEM_TIMEOUT), 1);
    chk("tmo_stall_cnt", int'(STALL_CNT), 300);
    adv();
    RST = 1;
    cyc();
    RST = 0;
    settle();
    chk("tmo_cleared", int'(MEM_TIMEOUT), 0);
    adv();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST        = ($urandom_range(0, 99) == 0);
      RS1_D      = 5'($urandom_range(0, 7));
      RS2_D      = 5'($urandom_range(0, 7));
      USE_RS1_D  = 1'($urandom);
      USE_RS2_D  = 1'($urandom);
      RD_E       = 5'($urandom_range(0, 7));
      WE_E       = 1'($urandom);
      LOAD_E     = 1'($urandom);
      BR_TAKEN_E = ($urandom_range(0, 7) == 0);
      RD_M       = 5'($urandom_range(0, 7));
      WE_M       = 1'($urandom);
      RD_W       = 5'($urandom_range(0, 7));
      WE_W       = 1'($urandom);
      DMEM_REQ_M = ($urandom_range(0, 3) == 0);
      DMEM_ACK_M = 1'($urandom);
      cyc();
    end

    // stall counter saturation
    do_reset();
    LOAD_E = 1; WE_E = 1; RD_E = 9; RS1_D = 9; USE_RS1_D = 1;
    for (int i = 0; i < 65540; i++) cyc();
    settle();
    chk("sat_cnt", int'(STALL_CNT), 65535);
    adv();
    cyc(); cyc();
    settle();
    chk("sat_hold", int'(STALL_CNT), 65535);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: CLK in 1 clock; RST in 1 reset, synchronous, active-high.
REQ-002 SHALL have inputs RS1_D, RS2_D in 5 (decode source regs) and USE_RS1_D, USE_RS2_D in 1 (source actually read).
REQ-003 SHALL have inputs RD_E in 5, WE_E in 1, LOAD_E in 1 (EX-stage destination, writes, is load), and BR_TAKEN_E in 1 (branch/jump redirect in EX).
REQ-004 SHALL have inputs RD_M in 5 and WE_M in 1 (MEM stage), RD_W in 5 and WE_W in 1 (WB stage), and DMEM_REQ_M, DMEM_ACK_M in 1 (data-memory request/acknowledge).
REQ-005 SHALL have outputs STALL_F, STALL_FD, STALL_DE, STALL_EM in 1 (hold PC / pipeline register), FLUSH_FD, FLUSH_DE, BUBBLE_MW in 1 (load NOP), FWD_A, FWD_B in 2 (operand select), STALL_CNT in 16, MEM_TIMEOUT in 1.

Function
REQ-006 SHALL implement FSM states RUN and MWAIT, with state registered on CLK.
REQ-007 SHALL go RUN->MWAIT when DMEM_REQ_M=1 and DMEM_ACK_M=0, and MWAIT->RUN in the cycle DMEM_ACK_M=1.
REQ-008 SHALL, on a memory wait (MWAIT, or RUN with REQ=1 and ACK=0), assert STALL_F/FD/DE/EM=1 and BUBBLE_MW=1, and hold FLUSH_* at 0; this is the highest priority.
REQ-009 SHALL, on a redirect (BR_TAKEN_E=1 with no memory wait), assert FLUSH_FD=1 and FLUSH_DE=1 for that cycle and hold stalls at 0; a branch frozen by MWAIT is applied on the cycle MWAIT exits.
REQ-010 SHALL detect a load-use hazard: LOAD_E=1, WE_E=1, RD_E!=0, RD_E equal to RS1_D (with USE_RS1_D) or RS2_D (with USE_RS2_D).
REQ-011 SHALL, on a load-use hazard with no redirect and no memory wait, assert STALL_F=1, STALL_FD=1, FLUSH_DE=1 for exactly one cycle per hazard.
REQ-012 SHALL apply priority: memory wait > redirect > load-use > RAW stall.
REQ-013 SHALL never flag a hazard or forward for register x0.
REQ-014 SHALL generate all outputs except STALL_CNT and MEM_TIMEOUT combinationally from inputs and state, with zero latency.
REQ-015 SHALL make STALL_CNT a saturating counter (holds at 0xFFFF) that increments each cycle STALL_F=1.
REQ-016 SHALL count MWAIT cycles in an 8-bit counter, cleared on entry to MWAIT; at the 255th consecutive cycle it SHALL set MEM_TIMEOUT, which stays set until RST.

Reset
REQ-017 SHALL, while RST=1, set state=RUN, STALL_CNT=0, MWAIT counter=0, MEM_TIMEOUT=0, FLUSH_FD=FLUSH_DE=1, all STALL_*=0, BUBBLE_MW=0, FWD_A=FWD_B=0.
REQ-018 SHALL, if RST asserts mid-MWAIT, return to RUN on the next edge regardless of DMEM_ACK_M.

Configuration
REQ-019 SHALL, with HAZARD_FWD_EN defined, drive FWD_x=01 on an EM match (WE_M, RD_M!=0, RD_M==RSx_D), else 10 on a WB match, else 00; EM takes priority over WB.
REQ-020 SHALL, without HAZARD_FWD_EN, tie FWD_A=FWD_B=00 and apply a RAW stall (STALL_F, STALL_FD, FLUSH_DE) while any used source matches a writing E or M stage; WB matches need no stall because the register file is write-through.

Structure
REQ-021 SHALL place FWD_RF=2'b00, FWD_EM=2'b01, FWD_MW=2'b10, the state encoding, and TIMEOUT_LIMIT=255 in package hazard_pkg.
REQ-022 SHALL instantiate sub-module hazard_fwd_sel, once per operand, to compute the source-match and forward select.

Verification
REQ-023 SHALL cover load-use: lw x5 in EX, RS1_D=5 -> one cycle of STALL_F=1, FLUSH_DE=1, then STALL_F=0 with FWD_A=10 when the FWD macro is on.
REQ-024 SHALL cover memory wait: REQ=1, ACK low for 3 cycles -> stalls=1 and BUBBLE_MW=1 for 3 cycles, STALL_CNT=3, RUN on the ACK cycle.
REQ-025 SHALL cover branch during MWAIT: BR_TAKEN_E=1 with ACK on cycle 2 -> FLUSH_FD/DE=0 during the wait and =1 on the exit cycle.
REQ-026 SHALL cover x0 and priority: RD_E=0 load with RS1_D=0 -> no stall; EM and WB both matching x7 -> FWD_A=01.
REQ-027 SHALL cover timeout and saturation: ACK held low 300 cycles -> MEM_TIMEOUT=1 from cycle 255, sticky until RST; STALL_CNT preset near max holds at 0xFFFF.
